lsu_mem_port: RTL

- CPU-side initiator for the data memory: takes one load/store request per instruction from the datapath and issues word-aligned bus beats with byte enables.
- Splits word-crossing (misaligned) halfword/word accesses into two beats and merges/sign-extends load data.
- Stalls the datapath until the access completes; a wait-cycle timeout reports a bus error.
- Sits between the execute/memory stage and the data memory port.

---
 rtl/lsu_mem_port_pkg.sv | 19 +
 rtl/lsu_mem_port_align.sv | 24 ++
 rtl/lsu_mem_port.sv | 123 ++++++++++++
 3 files changed

// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: func3 codes, LSU state encoding and access-size helpers
package lsu_mem_port_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_e;
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    return sz == 2'b00 ? 4'b0001 : sz == 2'b01 ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_SB || f3 == F3_SH || f3 == F3_SW)
              : (f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
  endfunction
endpackage

// File: rtl/lsu_mem_port_align.sv
// lsu_align: byte mask, lane-shifted store data and merged/extended load data
module lsu_align
  import lsu_mem_port_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] hi_i,
  output logic [6:0]  m7_o,
  output logic [63:0] wide_o,
  output logic [31:0] rdata_o
);
  logic [31:0] x;
  always_comb begin
    m7_o    = {3'b000, size_mask(func3_i[1:0])} << off_i;
    wide_o  = {32'h0, wdata_i} << {off_i, 3'b000};
    x       = 32'({hi_i, lo_i} >> {off_i, 3'b000});
    rdata_o = func3_i == F3_LB  ? {{24{x[7]}}, x[7:0]}   :
              func3_i == F3_LH  ? {{16{x[15]}}, x[15:0]} :
              func3_i == F3_LBU ? {24'h0, x[7:0]}        :
              func3_i == F3_LHU ? {16'h0, x[15:0]}       : x;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store bus initiator; cpu_* request/stall/done side, mem_* word-beat side
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_func3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  localparam logic [31:0] TO_LIM = 32'(TIMEOUT) - 32'd1;
  lsu_state_e  state_q, state_d;
  logic        we_q, we_d, err_q, err_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, lo_q, lo_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [6:0]  m7;
  logic [63:0] wide;
  logic [31:0] ld_data;
  logic        acc, b1;
  lsu_align u_align (
    .func3_i (f3_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .lo_i    (state_q == ACC0 ? mem_rdata : lo_q),
    .hi_i    (mem_rdata),
    .m7_o    (m7),
    .wide_o  (wide),
    .rdata_o (ld_data)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    err_d   = err_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (cpu_valid) begin
        we_d    = cpu_we;
        f3_d    = cpu_func3;
        addr_d  = cpu_addr;
        wdata_d = cpu_wdata;
        cnt_d   = '0;
        if (f3_valid(cpu_we, cpu_func3)) state_d = ACC0;
        else begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ACC0, ACC1: if (mem_ready) begin
        cnt_d = '0;
        if (state_q == ACC0 && |m7[6:4]) begin
          lo_d    = mem_rdata;
          state_d = ACC1;
        end else begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : ld_data;
        end
      end else if (TIMEOUT != 0 && cnt_q == TO_LIM) begin
        state_d = RESP;
        err_d   = 1'b1;
        rdata_d = '0;
      end else cnt_d = cnt_q + 32'd1;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    acc       = state_q == ACC0 || state_q == ACC1;
    b1        = state_q == ACC1;
    mem_req   = acc;
    mem_we    = acc && we_q;
    mem_addr  = acc ? {b1 ? addr_q[31:2] + 30'd1 : addr_q[31:2], 2'b00} : 32'h0;
    mem_be    = acc ? (b1 ? {1'b0, m7[6:4]} : m7[3:0]) : 4'h0;
    mem_wdata = acc ? (b1 ? wide[63:32] : wide[31:0]) : 32'h0;
    cpu_done  = state_q == RESP;
    cpu_stall = state_q != RESP && (cpu_valid || state_q != IDLE);
    cpu_rdata = rdata_q;
    cpu_err   = err_q;
  end
endmodule
